pipe_chain: RTL and testbench

- Parametrised elastic pipeline: STAGES register slots of DATA_W bits, each with its own valid bit, linked by a valid/ready handshake at both ends.
- Next generation of the fixed per-signal enable-register chains between the IF/ID/EXE/MEM/WB stages.
- Adds per-stage bubble collapsing, a synchronous flush for branch/jump squash, a global freeze and an occupancy count.
- Used as the inter-stage carrier for the next core revision and for multi-cycle units such as the multiplier and DRAM path.

---
 rtl/pipe_chain.sv | 136 +++++++++++++
 tb/tb_pipe_chain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: elastic valid/ready pipeline of STAGES register slots with
// bubble collapsing, synchronous flush, global freeze (enable) and an
// occupancy counter.
// Optional feature: define PIPE_CHAIN_SKID_EN to add a one-entry skid
// register ahead of slot 0, which makes in_ready a pure register function.
module pipe_chain #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned STAGES = 3,
   localparam int unsigned OCC_W  = $clog2(STAGES + 2)
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              enable,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   logic [STAGES-1:0] v;
   logic [DATA_W-1:0] d [STAGES];
   logic [STAGES-1:0] rdy;
   logic              tail_full;
   logic              in_fire;
   logic              out_fire;
   logic              src_valid;
   logic [DATA_W-1:0] src_data;

`ifdef PIPE_CHAIN_SKID_EN
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
`endif

   // Per-slot ready: a slot can load when it, or any slot downstream of it,
   // is empty, or when the consumer takes the last slot. Written as a
   // running "all full from here to the tail" term rather than a vector
   // that reads its own bits; equivalent to rdy[i] = !v[i] | rdy[i+1].
   always_comb begin
      tail_full = 1'b1;
      rdy       = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         tail_full             = tail_full & v[STAGES-1-k];
         rdy[STAGES-1-k]       = !tail_full | out_ready;
      end
   end

   // Handshake at both ends; flush and freeze block any transfer.
`ifdef PIPE_CHAIN_SKID_EN
   assign in_ready  = !skid_valid & enable & !flush;
`else
   assign in_ready  = rdy[0] & enable & !flush;
`endif
   assign out_valid = v[STAGES-1] & enable & !flush;
   assign out_data  = d[STAGES-1];
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Source feeding slot 0: a parked skid entry drains ahead of new input.
   always_comb begin
`ifdef PIPE_CHAIN_SKID_EN
      src_valid = skid_valid | in_fire;
      src_data  = skid_valid ? skid_data : in_data;
`else
      src_valid = in_fire;
      src_data  = in_data;
`endif
   end

   // Slot registers: advance every ready slot; data only moves under a
   // valid so bubbles leave the data registers untouched.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         v <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            d[k] <= '0;
         end
      end else if (flush) begin
         v <= '0;
      end else if (enable) begin
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
               v[k] <= v[k-1];
               if (v[k-1]) begin
                  d[k] <= d[k-1];
               end
            end
         end
         if (rdy[0]) begin
            v[0] <= src_valid;
            if (src_valid) begin
               d[0] <= src_data;
            end
         end
      end
   end

`ifdef PIPE_CHAIN_SKID_EN
   // Skid entry: catches an accepted word that slot 0 cannot take, and
   // empties into slot 0 as soon as slot 0 is ready.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (flush) begin
         skid_valid <= 1'b0;
      end else if (enable) begin
         if (skid_valid) begin
            if (rdy[0]) begin
               skid_valid <= 1'b0;
            end
         end else if (in_fire && !rdy[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
         end
      end
   end
`endif

   // Occupancy: entries accepted minus entries delivered; flush empties.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else if (in_fire && !out_fire) begin
         occupancy <= occupancy + OCC_W'(1);
      end else if (!in_fire && out_fire) begin
         occupancy <= occupancy - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed self-checking bench for pipe_chain (STAGES=3).
// Covers reset, streaming, backpressure, bubble collapse, flush, freeze,
// asynchronous reset mid-stream and, with PIPE_CHAIN_SKID_EN, the skid.
module tb_pipe_chain;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned STAGES = 3;
   localparam int unsigned OCC_W  = $clog2(STAGES + 2);
`ifdef PIPE_CHAIN_SKID_EN
   localparam int unsigned MAX_OCC       = STAGES + 1;
   localparam logic        FULL_IN_READY = 1'b1;
`else
   localparam int unsigned MAX_OCC       = STAGES;
   localparam logic        FULL_IN_READY = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              arst;
   logic              enable;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [OCC_W-1:0]  occupancy;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   pipe_chain #(
      .DATA_W (DATA_W),
      .STAGES (STAGES)
   ) dut (
      .clk       (clk),
      .arst      (arst),
      .enable    (enable),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // push one word and advance
   task automatic push(input logic [DATA_W-1:0] val);
      in_valid = 1'b1;
      in_data  = val;
      tick();
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!arst) begin
         assert (occupancy <= OCC_W'(MAX_OCC))
            else $error("occupancy above limit: %0d", occupancy);
         assert (!(occupancy == '0 && out_valid && out_ready))
            else $error("delivery with zero occupancy");
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      arst      = 1'b1;
      enable    = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // reset state
      #12;
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_out_data", 32'(out_data), 0);
      check_eq("rst_occ", 32'(occupancy), 0);
      arst = 1'b0;
      tick();
      @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 1);
      tick();

      // streaming: 0x11..0x18, first out 3 cycles after its in_fire
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (c < 8);
         in_data  = DATA_W'(8'h11 + c);
         @(negedge clk);
         if (c < 8) check_eq("stream_in_ready", 32'(in_ready), 1);
         if (c >= 3 && c <= 10) begin
            check_eq("stream_out_valid", 32'(out_valid), 1);
            check_eq("stream_out_data", 32'(out_data), 32'(8'h11 + c - 3));
         end else begin
            check_eq("stream_idle_valid", 32'(out_valid), 0);
         end
         if (c == 3)  check_eq("stream_occ_steady", 32'(occupancy), 3);
         if (c == 11) check_eq("stream_occ_empty", 32'(occupancy), 0);
         tick();
      end
      in_valid = 1'b0;

      // backpressure: fill, stall 5 cycles, release
      out_ready = 1'b0;
      push(8'hA0);
      push(8'hA1);
      push(8'hA2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_eq("bp_in_ready", 32'(in_ready), 32'(FULL_IN_READY));
         check_eq("bp_occ", 32'(occupancy), 3);
         check_eq("bp_out_valid", 32'(out_valid), 1);
         check_eq("bp_out_data", 32'(out_data), 32'h0A0);
         tick();
      end
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         if (r < 3) begin
            check_eq("bp_rel_valid", 32'(out_valid), 1);
            check_eq("bp_rel_data", 32'(out_data), 32'(8'hA0 + r));
            check_eq("bp_rel_occ", 32'(occupancy), 32'(3 - r));
         end else begin
            check_eq("bp_drained_valid", 32'(out_valid), 0);
            check_eq("bp_drained_occ", 32'(occupancy), 0);
         end
         tick();
      end

      // bubble collapse: 0x01, two idle cycles, 0x02, stalled output
      out_ready = 1'b0;
      push(8'h01);
      tick();
      tick();
      push(8'h02);
      tick();
      @(negedge clk);
      check_eq("bub_occ", 32'(occupancy), 2);
      check_eq("bub_in_ready", 32'(in_ready), 1);
      check_eq("bub_out_data", 32'(out_data), 32'h01);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bub_first_valid", 32'(out_valid), 1);
      check_eq("bub_first_data", 32'(out_data), 32'h01);
      tick();
      @(negedge clk);
      check_eq("bub_adjacent_valid", 32'(out_valid), 1);
      check_eq("bub_adjacent_data", 32'(out_data), 32'h02);
      tick();
      @(negedge clk);
      check_eq("bub_empty_occ", 32'(occupancy), 0);
      tick();

      // flush with a word offered in the flush cycle
      out_ready = 1'b0;
      push(8'hC0);
      push(8'hC1);
      push(8'hC2);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hDD;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("flush_in_ready", 32'(in_ready), 0);
      check_eq("flush_out_valid", 32'(out_valid), 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("flush_occ", 32'(occupancy), 0);
      check_eq("flush_data_kept", 32'(out_data), 32'h0C0);
      check_eq("flush_in_ready_after", 32'(in_ready), 1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("flush_no_output", 32'(out_valid), 0);
         tick();
      end

      // freeze: enable low for 4 cycles, offering input and accepting output
      out_ready = 1'b0;
      push(8'hE0);
      push(8'hE1);
      enable    = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hEF;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("frz_in_ready", 32'(in_ready), 0);
         check_eq("frz_out_valid", 32'(out_valid), 0);
         check_eq("frz_occ", 32'(occupancy), 2);
         tick();
      end
      enable    = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("frz_held_valid", 32'(out_valid), 0);
      check_eq("frz_held_occ", 32'(occupancy), 2);
      tick();
      @(negedge clk);
      check_eq("frz_resume_data", 32'(out_data), 32'h0E0);

      // asynchronous reset mid-stream, away from any clock edge
      tick();
      out_ready = 1'b1;
      #1;
      arst     = 1'b1;
      in_valid = 1'b0;
      #1;
      check_eq("arst_occ", 32'(occupancy), 0);
      check_eq("arst_out_data", 32'(out_data), 0);
      check_eq("arst_out_valid", 32'(out_valid), 0);
      @(negedge clk);
      arst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clk);
         check_eq("arst_lost_valid", 32'(out_valid), 0);
      end
      tick();

`ifdef PIPE_CHAIN_SKID_EN
      // skid: one extra word accepted into a full chain, exits last
      out_ready = 1'b0;
      push(8'h51);
      push(8'h52);
      push(8'h53);
      in_valid = 1'b1;
      in_data  = 8'h54;
      @(negedge clk);
      check_eq("skid_accept", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("skid_occ", 32'(occupancy), 4);
      check_eq("skid_in_ready", 32'(in_ready), 0);
      tick();
      out_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         @(negedge clk);
         if (r < 4) begin
            check_eq("skid_rel_valid", 32'(out_valid), 1);
            check_eq("skid_rel_data", 32'(out_data), 32'(8'h51 + r));
            check_eq("skid_rel_occ", 32'(occupancy), 32'(4 - r));
         end else begin
            check_eq("skid_drained_valid", 32'(out_valid), 0);
            check_eq("skid_drained_occ", 32'(occupancy), 0);
         end
         tick();
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
